// File: rtl/gpu_pkg.sv
// Shared definitions for the voxel fill engine: register map, FSM states,
// master beat payload and lane helpers.
package gpu_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [7:0] REG_PIXEL_BUFFER = 8'h00;
    localparam logic [7:0] REG_FILL_COLOR   = 8'h01;
    localparam logic [7:0] REG_STATUS       = 8'h03;
    localparam logic [7:0] REG_IRQ_EN       = 8'h04;
    localparam logic [7:0] REG_TRIGGER      = 8'h0f;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] writedata;
        logic [BE_W-1:0]   byteenable;
    } m1_beat_t;

    // Copy the low pixel_bytes of the colour into every byte lane
    function automatic logic [31:0] replicate_color(input logic [31:0] color,
                                                    input int unsigned pixel_bytes);
        logic [31:0] r;
        case (pixel_bytes)
            1:       r = {4{color[7:0]}};
            2:       r = {2{color[15:0]}};
            default: r = color;
        endcase
        return r;
    endfunction

    // Byte lanes covered by one pixel starting at the given byte offset
    function automatic logic [3:0] lane_mask(input logic [1:0] offset,
                                             input int unsigned pixel_bytes);
        logic [7:0] m;
        case (pixel_bytes)
            1:       m = 8'h01;
            2:       m = 8'h03;
            default: m = 8'h0F;
        endcase
        m = m << offset;
        return m[3:0];
    endfunction

endpackage

// File: rtl/voxel_fill_addr_gen.sv
// Pixel index counter and master address / byte-enable generation.
module voxel_fill_addr_gen
    import gpu_pkg::*;
#(
    parameter int unsigned PIXEL_BYTES = 2,
    parameter logic [31:0] LAST_INDEX  = 32'd0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_advance,
    input  logic [ADDR_W-1:0] i_base,
    output logic [ADDR_W-1:0] o_address,
    output logic [BE_W-1:0]   o_byteenable,
    output logic              o_last
);

    logic [31:0]       r_index;
    logic [ADDR_W-1:0] w_address;

    // Index restarts on a fresh fill and advances on each accepted beat but never past the last pixel
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_index <= 32'd0;
        end else if (i_start) begin
            r_index <= 32'd0;
        end else if (i_advance && !o_last) begin
            r_index <= r_index + 32'd1;
        end
    end

    assign w_address    = i_base + (r_index * 32'(PIXEL_BYTES));
    assign o_address    = w_address;
    assign o_byteenable = lane_mask(w_address[1:0], PIXEL_BYTES);
    assign o_last       = (r_index == LAST_INDEX);

endmodule

// File: rtl/voxel_fill_engine.sv
// Frame-buffer fill engine: Avalon-MM register slave plus write-only master
// that writes one colour into every pixel of the frame.
// Optional macro VOXEL_FILL_IRQ_EN enables the irq_enable register and irq output.
module voxel_fill_engine
    import gpu_pkg::*;
#(
    parameter logic [31:0] DEFAULT_BUFFER = 32'h0800_0000,
    parameter logic [15:0] H_RESOLUTION   = 16'd256,
    parameter logic [15:0] V_RESOLUTION   = 16'd192,
    parameter int unsigned PIXEL_BYTES    = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [7:0]        s1_address,
    input  logic [DATA_W-1:0] s1_writedata,
    input  logic              s1_write,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_waitrequest,
    output logic [ADDR_W-1:0] m1_address,
    output logic [DATA_W-1:0] m1_writedata,
    output logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_write,
    input  logic              m1_waitrequest,
    output logic              irq
);

    localparam logic [31:0] LAST_INDEX = (32'(H_RESOLUTION) * 32'(V_RESOLUTION)) - 32'd1;
    localparam logic [31:0] COLOR_MASK = (PIXEL_BYTES == 4) ? 32'hFFFF_FFFF :
                                         (PIXEL_BYTES == 2) ? 32'h0000_FFFF : 32'h0000_00FF;

    fill_state_e       r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_m1_write;
    logic [ADDR_W-1:0] r_pixel_buffer;
    logic [DATA_W-1:0] r_fill_color;
    logic [ADDR_W-1:0] r_work_base;
    logic [DATA_W-1:0] r_work_data;

    logic              w_wr_pixel;
    logic              w_wr_color;
    logic              w_wr_status;
    logic              w_wr_trigger;
    logic              w_start;
    logic              w_beat_done;
    logic              w_last;
    logic              w_done_next;
    logic              w_irq_en_rd;
    m1_beat_t          w_beat;

    assign w_wr_pixel   = s1_write && (s1_address == REG_PIXEL_BUFFER);
    assign w_wr_color   = s1_write && (s1_address == REG_FILL_COLOR);
    assign w_wr_status  = s1_write && (s1_address == REG_STATUS);
    assign w_wr_trigger = s1_write && (s1_address == REG_TRIGGER);
    assign w_start      = (r_state == ST_IDLE) && w_wr_trigger;
    assign w_beat_done  = (r_state == ST_FILL) && !m1_waitrequest;

    // Done flag: W1C clear, but the DONE-state set takes priority
    always_comb begin
        w_done_next = r_done;
        if (w_wr_status && s1_writedata[1]) begin
            w_done_next = 1'b0;
        end
        if (r_state == ST_DONE) begin
            w_done_next = 1'b1;
        end
    end

    // Programmable registers and the done flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pixel_buffer <= DEFAULT_BUFFER;
            r_fill_color   <= '0;
            r_done         <= 1'b0;
        end else begin
            if (w_wr_pixel) begin
                r_pixel_buffer <= s1_writedata;
            end
            if (w_wr_color) begin
                r_fill_color <= s1_writedata & COLOR_MASK;
            end
            r_done <= w_done_next;
        end
    end

`ifdef VOXEL_FILL_IRQ_EN
    logic r_irq_en;
    logic r_irq;
    logic w_wr_irq_en;
    logic w_irq_en_next;

    assign w_wr_irq_en   = s1_write && (s1_address == REG_IRQ_EN);
    assign w_irq_en_next = w_wr_irq_en ? s1_writedata[0] : r_irq_en;

    // Interrupt enable and level interrupt tracking done & enable
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_irq_en <= w_irq_en_next;
            r_irq    <= w_done_next & w_irq_en_next;
        end
    end

    assign irq         = r_irq;
    assign w_irq_en_rd = r_irq_en;
`else
    assign irq         = 1'b0;
    assign w_irq_en_rd = 1'b0;
`endif

    // Fill sequencer: working copies are captured at trigger so register writes mid-fill do not disturb it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_m1_write  <= 1'b0;
            r_work_base <= '0;
            r_work_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_trigger) begin
                        r_work_base <= r_pixel_buffer;
                        r_work_data <= replicate_color(r_fill_color, PIXEL_BYTES);
                        r_busy      <= 1'b1;
                        r_m1_write  <= 1'b1;
                        r_state     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_beat_done && w_last) begin
                        r_m1_write <= 1'b0;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy     <= 1'b0;
                    r_m1_write <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    voxel_fill_addr_gen #(
        .PIXEL_BYTES (PIXEL_BYTES),
        .LAST_INDEX  (LAST_INDEX)
    ) u_addr_gen (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_start      (w_start),
        .i_advance    (w_beat_done),
        .i_base       (r_work_base),
        .o_address    (w_beat.address),
        .o_byteenable (w_beat.byteenable),
        .o_last       (w_last)
    );

    assign w_beat.writedata = r_work_data;

    assign m1_address    = w_beat.address;
    assign m1_writedata  = w_beat.writedata;
    assign m1_byteenable = w_beat.byteenable;
    assign m1_write      = r_m1_write;

    // Combinational register read-back; unmapped and write-only addresses return 0
    always_comb begin
        s1_readdata = '0;
        case (s1_address)
            REG_PIXEL_BUFFER: s1_readdata = r_pixel_buffer;
            REG_FILL_COLOR:   s1_readdata = r_fill_color;
            REG_STATUS:       s1_readdata = {30'd0, r_done, r_busy};
            REG_IRQ_EN:       s1_readdata = {31'd0, w_irq_en_rd};
            default:          s1_readdata = '0;
        endcase
    end

    assign s1_waitrequest = 1'b0;

endmodule
